// File: rtl/nf_pkg.sv
// Shared constants for the NullFresh S-box compression stage.
// nf_grp maps a coordinate-function instance to the output share it feeds.
package nf_pkg;

    localparam int unsigned NF_SHARES = 3;
    localparam int unsigned NF_NCF    = 18;
    localparam int unsigned NF_GROUP  = 6;

    function automatic int unsigned nf_grp(input int unsigned k);
        return (k / NF_GROUP) + 1;
    endfunction

endpackage

// File: rtl/nf_xor6.sv
// Six-input XOR for one bit of one compressed share.
module nf_xor6 (
    input  logic [5:0] d,
    output logic       y
);

    assign y = ^d;

endmodule

// File: rtl/nf_cf_compress.sv
// Glitch-barrier register plus XOR compression of 18 coordinate outputs
// into 3 shares per bit, as a 2-entry elastic valid/ready pipeline.
module nf_cf_compress
    import nf_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCF   = NF_NCF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCF*WIDTH-1:0] cf_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     sh1,
    output logic [WIDTH-1:0]     sh2,
    output logic [WIDTH-1:0]     sh3,
    output logic                 busy
);

    logic v1;
    logic v2;
    logic s1_load;
    logic s2_load;

    // Kept as a real register so the compression XOR cannot be pulled across it.
    (* keep = "true" *) logic [NCF*WIDTH-1:0] r1;

    logic [NF_SHARES-1:0][WIDTH-1:0][NF_GROUP-1:0] xin;
    logic [NF_SHARES-1:0][WIDTH-1:0]               cmp;

    assign s2_load   = v1 && (!v2 || out_ready);
    assign in_ready  = !v1 || s2_load;
    assign s1_load   = in_valid && in_ready;
    assign out_valid = v2;
    assign busy      = v1 | v2;

    for (genvar k = 0; k < NCF; k++) begin : g_inst
        localparam int unsigned G = nf_grp(k) - 1;
        localparam int unsigned J = k % NF_GROUP;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign xin[G][i][J] = r1[k*WIDTH+i];
        end
    end

    for (genvar s = 0; s < NF_SHARES; s++) begin : g_share
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            nf_xor6 u_xor (
                .d (xin[s][i]),
                .y (cmp[s][i])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (s1_load)      v1 <= 1'b1;
            else if (s2_load) v1 <= 1'b0;

            if (s2_load)        v2 <= 1'b1;
            else if (out_ready) v2 <= 1'b0;
        end
    end

    // Data registers only move on a load so idle cycles cause no transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1  <= '0;
            sh1 <= '0;
            sh2 <= '0;
            sh3 <= '0;
        end else begin
            if (s1_load) r1 <= cf_q;
            if (s2_load) begin
                sh1 <= cmp[0];
                sh2 <= cmp[1];
                sh3 <= cmp[2];
            end
        end
    end

endmodule

// File: doc/nf_cf_compress.md
# nf_cf_compress

Pipelined register-and-compression stage downstream of the 18 second-order NullFresh coordinate-function instances of one masked SKINNY S-box quadratic layer. Registers all 18 coordinate outputs per bit as a glitch barrier, then XOR-compresses them into 3 output shares per bit in a second register stage. Flow control is a valid/ready handshake, so the S-box pipeline can stall without losing or corrupting shares.

## Interface
Parameters:
- WIDTH, 4, bits per share (nibble S-box layer).
- NCF, 18, coordinate outputs per bit; fixed, must be 18.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  coordinate-function outputs valid this cycle.
- in_ready  out  1  stage 1 can accept.
- cf_q  in  NCF*WIDTH  coordinate outputs; bit i of instance k at index k*WIDTH+i, k=0..17.
- out_valid  out  1  compressed shares valid.
- out_ready  in  1  downstream accepts.
- sh1, sh2, sh3  out  WIDTH each  output shares.
- busy  out  1  any stage holds valid data.

## Operation
- Stage 1 (S1): register r1[k][i] <= cf_q[k*WIDTH+i] for all k, i when in_valid && in_ready. No logic between cf_q and r1.
- Stage 2 (S2): compress from r1 only, never from cf_q:
  - sh1[i] = XOR of r1[0..5][i].
  - sh2[i] = XOR of r1[6..11][i].
  - sh3[i] = XOR of r1[12..17][i].
  - Result is registered into sh1/sh2/sh3 when S2 loads.
- Grouping is fixed. A group must never mix instances from different ranges; doing so breaks the non-completeness argument.
- Valid flags v1 and v2 form a 2-entry elastic pipeline:
  - S2 loads when v1 && (!v2 || out_ready).
  - S1 loads when in_valid && in_ready.
  - in_ready = !v1 || S2 loads (combinational from v1, v2, out_ready).
  - v1 next = S1 loads ? 1 : (S2 loads ? 0 : v1).
  - v2 next = S2 loads ? 1 : ((v2 && out_ready) ? 0 : v2).
- Data registers hold their value when not loading. They must not toggle on invalid cycles, to avoid extra leakage transitions.
- out_valid = v2; busy = v1 | v2.
- sh1/sh2/sh3 are registered outputs with no combinational path from any input.

## Timing
- Reset (async assert, sync release by the system): v1=0, v2=0, r1 all 0, sh1=sh2=sh3=0, out_valid=0, busy=0, in_ready=1.
- Latency: a word accepted at edge t appears on sh* with out_valid=1 after edge t+1, assuming no stall.
- Throughput: one word per cycle while out_ready=1.
- Full condition: v1=v2=1 and out_ready=0 → in_ready=0; cf_q is ignored.
- Simultaneous drain and fill: with v1=v2=1 and out_ready=1 in the same cycle, S2 takes r1, S1 takes a new word, and in_ready=1.
- Holding: out_valid stays asserted and sh* stay stable until out_ready is sampled high.
- Reset mid-operation: in-flight words are discarded, with no partial output.
- First cycle after release: in_ready=1.

## Structure
- Shared package nf_pkg:
  - constants NF_SHARES=3, NF_NCF=18, NF_GROUP=6.
  - function nf_grp(k) returning the output share index 1..3 for instance k.
- One sub-module, nf_xor6, is natural: a 6-input XOR for one bit of one share. Instantiate it 3*WIDTH times, with inputs driven only from r1.
- The compression XOR must not be merged across the register boundary by synthesis; apply the keep attribute on r1.

## Test plan
- Reset: assert rst_n=0 mid-stream with v1=v2=1 → out_valid=0 and sh1/sh2/sh3=0 immediately; in_ready=1 after release.
- Single word: cf_q with instances 0 and 7 = 4'hF, all others 0, in_valid for one cycle, out_ready=1 → two edges later out_valid=1, sh1=4'hF, sh2=4'hF, sh3=4'h0; out_valid drops one cycle later.
- Group boundary: instance 5 = 4'h1, 6 = 4'h2, 11 = 4'h4, 12 = 4'h8, 17 = 4'h8 → sh1=4'h1, sh2=4'h6, sh3=4'h0.
- Backpressure: stream 3 words with out_ready=0 → in_ready=0 after 2 are accepted; when out_ready rises, outputs follow in order with no loss or duplicate, and sh* stay stable while stalled.
- Full throughput: 16 random words back-to-back, out_ready=1 → 16 consecutive out_valid cycles. The XOR of sh1^sh2^sh3 must equal the XOR of all 18 instances for each word.
- Quiet inputs: toggle cf_q randomly with in_valid=0 → r1 and sh* do not change.
